mem_port_arbiter: RTL and testbench

//  Shares the single memory port (mem_addr/mem_rd_data/mem_wr_*/mem_access/mem_exception) between
//  two requesters: port 0 = rv32i multicycle core, port 1 = DMA/debug master.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between the core (port 0) and a DMA/debug master (port 1).
// One outstanding transaction; the response returns MEM_LATENCY cycles after issue.
package mem_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;
    typedef logic [1:0] mem_exception_mask_t;
endpackage

module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [1:0]          req,
    input  logic [31:0]         addr0,
    input  logic [31:0]         addr1,
    input  logic [31:0]         wr_data0,
    input  logic [31:0]         wr_data1,
    input  logic                wr_ena0,
    input  logic                wr_ena1,
    input  mem_access_t         access0,
    input  mem_access_t         access1,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [31:0]         rd_data,
    output mem_exception_mask_t exception,
    output logic                busy,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wr_data,
    output logic                mem_wr_ena,
    output mem_access_t         mem_access,
    input  logic [31:0]         mem_rd_data,
    input  mem_exception_mask_t mem_exception
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

    logic [1:0]  state;
    logic [2:0]  lat_cnt;
    logic        last_grant;
    logic        hold_port;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic        hold_we;
    mem_access_t hold_acc;
    logic        issue;
    logic        win;

    assign issue = (state == S_IDLE) && ena && |req;
    // On a tie the port that did not win last time goes next.
    assign win = (req == 2'b11) ? ~last_grant : req[1];

    always_comb begin
        gnt         = issue ? (win ? 2'b10 : 2'b01) : 2'b00;
        rvalid      = (state == S_RESP) ? (hold_port ? 2'b10 : 2'b01) : 2'b00;
        busy        = (state != S_IDLE) || issue;
        mem_addr    = issue ? (win ? addr1 : addr0) : hold_addr;
        mem_wr_data = issue ? (win ? wr_data1 : wr_data0) : hold_wdata;
        mem_wr_ena  = issue && (win ? wr_ena1 : wr_ena0);
        mem_access  = issue ? (win ? access1 : access0) : hold_acc;
        rd_data     = mem_rd_data;
        exception   = mem_exception;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            last_grant <= 1'b1;
            hold_port  <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_we    <= 1'b0;
            hold_acc   <= MEM_ACCESS_WORD;
        end else if (issue) begin
            state      <= (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
            lat_cnt    <= LAT_M1;
            last_grant <= win;
            hold_port  <= win;
            hold_addr  <= mem_addr;
            hold_wdata <= mem_wr_data;
            hold_we    <= mem_wr_ena;
            hold_acc   <= mem_access;
        end else if (state == S_WAIT) begin
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt <= 3'd1)
                state <= S_RESP;
        end else if (state != S_IDLE) begin
            state <= S_IDLE;
        end
    end

    logic unused_hold_we;
    assign unused_hold_we = hold_we;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (latency 1 and 3) share directed stimulus; a transaction-level
// model checks every cycle and literal checks pin the scenario results.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic [1:0] req = 2'b00;
    logic [31:0] addr0 = '0, addr1 = '0, wr_data0 = '0, wr_data1 = '0;
    logic wr_ena0 = 1'b0, wr_ena1 = 1'b0;
    mem_access_t access0 = MEM_ACCESS_WORD, access1 = MEM_ACCESS_WORD;

    logic [1:0] gnt1, rv1, gnt3, rv3;
    logic [31:0] rd1, rd3, ma1, ma3, mwd1, mwd3, mrd1, mrd3;
    logic busy1, busy3, mwe1, mwe3;
    mem_exception_mask_t ex1, ex3, mex1, mex3;
    mem_access_t macc1, macc3;
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .addr0(addr0), .addr1(addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ena0(wr_ena0), .wr_ena1(wr_ena1),
        .access0(access0), .access1(access1), .gnt(gnt1), .rvalid(rv1), .rd_data(rd1),
        .exception(ex1), .busy(busy1), .mem_addr(ma1), .mem_wr_data(mwd1), .mem_wr_ena(mwe1),
        .mem_access(macc1), .mem_rd_data(mrd1), .mem_exception(mex1));

    mem_port_arbiter #(.MEM_LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .addr0(addr0), .addr1(addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ena0(wr_ena0), .wr_ena1(wr_ena1),
        .access0(access0), .access1(access1), .gnt(gnt3), .rvalid(rv3), .rd_data(rd3),
        .exception(ex3), .busy(busy3), .mem_addr(ma3), .mem_wr_data(mwd3), .mem_wr_ena(mwe3),
        .mem_access(macc3), .mem_rd_data(mrd3), .mem_exception(mex3));

    // Memories hold their address-derived contents stably while the arbiter keeps mem_addr steady.
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 64; i++) mem1[i] <= 32'hA5A5_0000 | 32'(i);
        else if (mwe1) mem1[ma1[7:2]] <= mwd1;
    end
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 64; i++) mem3[i] <= 32'hA5A5_0000 | 32'(i);
        else if (mwe3) mem3[ma3[7:2]] <= mwd3;
    end
    assign mrd1 = mem1[ma1[7:2]];
    assign mrd3 = mem3[ma3[7:2]];
    assign mex1 = {ma1[31], ma1[1:0] != 2'b00};
    assign mex3 = {ma3[31], ma3[1:0] != 2'b00};

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", n, a, e);
        end
    endtask

    // Transaction model: an issue at cycle t owns the port until its response at cycle t+latency.
    logic        infl [2];
    int          t_iss [2];
    logic        prt [2];
    logic        last [2];
    logic [31:0] ha [2];
    logic [31:0] hw [2];
    logic        hwe [2];
    logic [1:0]  hac [2];
    logic [31:0] sh [2][64];

    task automatic step(input int d, input int lat, input logic [1:0] g, input logic [1:0] rv,
                        input logic b, input logic [31:0] ma, input logic [31:0] mwd,
                        input logic mwe, input logic [1:0] macc, input logic [31:0] rd,
                        input logic [1:0] ex);
        logic [1:0] eg, erv, eacc;
        logic eb, ewe, w;
        logic [31:0] ea, ewd;
        string p;
        p = (d == 0) ? "L1" : "L3";
        eg = 2'b00; erv = 2'b00; eb = 1'b0; ewe = 1'b0;
        ea = ha[d]; ewd = hw[d]; eacc = hac[d];
        if (rst) begin
            infl[d] = 1'b0; last[d] = 1'b1; ha[d] = '0; hw[d] = '0; hwe[d] = 1'b0;
            hac[d] = 2'(MEM_ACCESS_WORD); prt[d] = 1'b0;
            for (int i = 0; i < 64; i++) sh[d][i] = 32'hA5A5_0000 | 32'(i);
            ea = '0; ewd = '0; eacc = 2'(MEM_ACCESS_WORD);
        end else if (infl[d]) begin
            eb = 1'b1;
            if (cyc - t_iss[d] == lat) begin
                erv = prt[d] ? 2'b10 : 2'b01;
                infl[d] = 1'b0;
                if (!hwe[d]) chk({p, "_rd_data"}, rd, sh[d][ha[d][7:2]]);
                chk({p, "_exception"}, 32'(ex), 32'({ha[d][31], |ha[d][1:0]}));
            end
        end else if (ena && req != 2'b00) begin
            w = (req == 2'b11) ? !last[d] : req[1];
            eg = w ? 2'b10 : 2'b01; eb = 1'b1;
            ea = w ? addr1 : addr0; ewd = w ? wr_data1 : wr_data0;
            ewe = w ? wr_ena1 : wr_ena0; eacc = w ? 2'(access1) : 2'(access0);
            infl[d] = 1'b1; t_iss[d] = cyc; prt[d] = w; last[d] = w;
            ha[d] = ea; hw[d] = ewd; hwe[d] = ewe; hac[d] = eacc;
            if (ewe) sh[d][ea[7:2]] = ewd;
        end
        chk({p, "_gnt"}, 32'(g), 32'(eg));
        chk({p, "_rvalid"}, 32'(rv), 32'(erv));
        chk({p, "_busy"}, 32'(b), 32'(eb));
        chk({p, "_mem_addr"}, ma, ea);
        chk({p, "_mem_wr_data"}, mwd, ewd);
        chk({p, "_mem_wr_ena"}, 32'(mwe), 32'(ewe));
        chk({p, "_mem_access"}, 32'(macc), 32'(eacc));
    endtask

    always @(negedge clk) begin
        cyc++;
        step(0, 1, gnt1, rv1, busy1, ma1, mwd1, mwe1, macc1, rd1, ex1);
        step(1, 3, gnt3, rv3, busy3, ma3, mwd3, mwe3, macc3, rd3, ex3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 2'b00;
        repeat (n) tick();
    endtask

    int n, bcnt, rv_at, seen;
    logic ord [6];
    int tg [6];
    logic stable;
    logic [31:0] rv_data;

    initial begin
        tick();
        tick();
        @(negedge clk);
        chk("reset_gnt", 32'(gnt1 | gnt3), 0);
        chk("reset_busy", 32'(busy1 | busy3), 0);
        chk("reset_mem_addr", ma1 | ma3, 0);
        chk("reset_access", 32'(macc1), 32'(MEM_ACCESS_WORD));
        tick();
        rst = 1'b0;
        tick();

        // single read on port 0
        req = 2'b01; addr0 = 32'h1000_0010; wr_ena0 = 1'b0;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt1), 32'h1);
        chk("t1_mem_addr", ma1, 32'h1000_0010);
        tick();
        req = 2'b00;
        @(negedge clk);
        chk("t1_rvalid", 32'(rv1), 32'h1);
        chk("t1_rd_data", rd1, 32'hA5A5_0004);
        idle(6);

        // write on port 1, then read it back
        req = 2'b10; addr1 = 32'h1000_0020; wr_data1 = 32'hDEAD_BEEF; wr_ena1 = 1'b1;
        @(negedge clk);
        chk("t3_gnt", 32'(gnt1), 32'h2);
        chk("t3_wr_ena_issue", 32'(mwe1), 32'h1);
        chk("t3_wr_data", mwd1, 32'hDEAD_BEEF);
        tick();
        req = 2'b00; wr_ena1 = 1'b0;
        @(negedge clk);
        chk("t3_rvalid", 32'(rv1), 32'h2);
        chk("t3_wr_ena_after", 32'(mwe1), 32'h0);
        idle(6);
        req = 2'b10;
        tick();
        req = 2'b00;
        @(negedge clk);
        chk("t3_readback", rd1, 32'hDEAD_BEEF);
        idle(6);

        // tie held: grants alternate, one every two cycles
        req = 2'b11; addr0 = 32'h1000_0000; addr1 = 32'h1000_0004;
        n = 0;
        for (int k = 0; k < 20 && n < 6; k++) begin
            @(negedge clk);
            if (gnt1 != 2'b00) begin
                ord[n] = gnt1[1];
                tg[n] = k;
                n++;
            end
            if (n < 6) tick();
        end
        tick();
        req = 2'b00;
        chk("t2_grant_count", 32'(n), 6);
        for (int i = 0; i < n; i++) begin
            chk("t2_order", 32'(ord[i]), 32'(i % 2));
            if (i > 0) chk("t2_spacing", 32'(tg[i] - tg[i-1]), 2);
        end
        idle(6);

        // latency 3: response three cycles after grant
        req = 2'b01; addr0 = 32'h1000_0030;
        @(negedge clk);
        chk("t4_gnt", 32'(gnt3), 32'h1);
        bcnt = busy3 ? 1 : 0; rv_at = -1; stable = 1'b1; rv_data = '0;
        tick();
        req = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (busy3) begin
                bcnt++;
                if (ma3 != 32'h1000_0030) stable = 1'b0;
            end
            if (rv3 == 2'b01) begin
                rv_at = k;
                rv_data = rd3;
            end
            tick();
        end
        chk("t4_rvalid_delay", 32'(rv_at), 3);
        chk("t4_busy_cycles", 32'(bcnt), 4);
        chk("t4_addr_stable", 32'(stable), 1);
        chk("t4_rd_data", rv_data, 32'hA5A5_000C);
        idle(2);

        // ena low blocks grants; a misaligned high address raises both exception bits
        ena = 1'b0; req = 2'b01; addr0 = 32'h8000_0013; access0 = MEM_ACCESS_BYTE;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (gnt1 != 2'b00 || gnt3 != 2'b00) seen++;
            tick();
        end
        chk("t5_no_gnt_disabled", 32'(seen), 0);
        ena = 1'b1;
        @(negedge clk);
        chk("t5_gnt_enabled", 32'(gnt1), 32'h1);
        chk("t5_access", 32'(macc1), 32'(MEM_ACCESS_BYTE));
        tick();
        req = 2'b00; access0 = MEM_ACCESS_WORD;
        @(negedge clk);
        chk("t5_exception", 32'(ex1), 32'h3);
        idle(6);
        ena = 1'b0; req = 2'b01;
        tick();
        req = 2'b00; ena = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (gnt1 != 2'b00 || rv1 != 2'b00) seen++;
            tick();
        end
        chk("t5_withdrawn", 32'(seen), 0);

        // reset while waiting on memory drops the transaction
        req = 2'b11;
        @(negedge clk);
        chk("t6_gnt_before", 32'(gnt3), 32'h2);
        tick();
        req = 2'b00;
        @(negedge clk);
        chk("t6_busy_wait", 32'(busy3), 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy_rst", 32'(busy3), 0);
        chk("t6_rvalid_rst", 32'(rv3), 0);
        chk("t6_addr_rst", ma3, 0);
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rv3 != 2'b00) seen++;
            tick();
        end
        chk("t6_no_rvalid", 32'(seen), 0);
        req = 2'b11;
        @(negedge clk);
        chk("t6_tie_after_rst", 32'(gnt3), 32'h1);
        tick();
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
